sort_controller: RTL and testbench

Sequential sorter built around one shared comparator_32bit instance (signed gt/eq). It accepts DEPTH signed 32-bit words over a valid/ready input stream and bubble-sorts them in an internal register array, performing one comparison per cycle. It then streams the sorted words out over a valid/ready output. It is the first sequencing controller placed in front of the comparator datapath.

---
 rtl/sort_if.sv | 21 ++
 rtl/sort_controller.sv | 162 ++++++++++++++++
 tb/tb_sort_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sort_if.sv
// Valid/ready word streams into and out of sort_controller.
// slave: DUT side; master: producer/consumer side.
interface sort_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        descending;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport slave (
        input  in_valid, in_data, descending, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, descending, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sort_controller.sv
// Batch bubble sorter around one shared signed comparator.
// Ports: clk, rst_n, bus (sort_if.slave), busy, done, swap_count.
module comparator_32bit (
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    output logic        gt,
    output logic        eq
);
    assign gt = $signed(input1) > $signed(input2);
    assign eq = input1 == input2;
endmodule

module sort_controller #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sort_if.slave            bus,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] swap_count
);
    localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST2 = IW'(DEPTH - 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SORT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    state;
    logic [31:0]   mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] idx;
    logic [IW-1:0] pass_cnt;
    logic          pass_swapped;
    logic          order;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_data;

    logic [31:0]   cmp_a;
    logic [31:0]   cmp_b;
    logic          gt;
    logic          eq;
    logic          swap;
    logic [IW-1:0] idx_nx;
    logic [IW-1:0] rd_nx;
    logic          any_swap;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;

    assign idx_nx = idx + IW'(1);
    assign rd_nx  = rd_idx + IW'(1);
    assign cmp_a  = mem[idx];
    assign cmp_b  = mem[idx_nx];

    comparator_32bit u_cmp (
        .input1 (cmp_a),
        .input2 (cmp_b),
        .gt     (gt),
        .eq     (eq)
    );

    // Strict inequality in both orders keeps equal words in place.
    assign swap = (state == SORT) &&
                  (order ? (!gt && !eq) : gt);
    assign any_swap = pass_swapped | swap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            wr_idx       <= '0;
            rd_idx       <= '0;
            idx          <= '0;
            pass_cnt     <= '0;
            pass_swapped <= 1'b0;
            order        <= 1'b0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            swap_count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    if (bus.in_valid && in_ready) begin
                        mem[wr_idx] <= bus.in_data;
                        if (wr_idx == '0) begin
                            order      <= bus.descending;
                            swap_count <= '0;
                        end
                        if (wr_idx == LAST) begin
                            wr_idx       <= '0;
                            in_ready     <= 1'b0;
                            busy         <= 1'b1;
                            idx          <= '0;
                            pass_cnt     <= IW'(1);
                            pass_swapped <= 1'b0;
                            state        <= SORT;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                SORT: begin
                    if (swap) begin
                        mem[idx]    <= cmp_b;
                        mem[idx_nx] <= cmp_a;
                        if (swap_count != '1)
                            swap_count <= swap_count + CNT_W'(1);
                    end
                    if (idx == LAST2) begin
                        if (!any_swap || pass_cnt == LAST) begin
                            done      <= 1'b1;
                            out_valid <= 1'b1;
                            // mem[0] may be rewritten on this very edge.
                            out_data  <= (swap && idx == '0) ?
                                         cmp_b : mem[0];
                            rd_idx    <= '0;
                            state     <= DRAIN;
                        end else begin
                            idx          <= '0;
                            pass_swapped <= 1'b0;
                            pass_cnt     <= pass_cnt + IW'(1);
                        end
                    end else begin
                        idx          <= idx_nx;
                        pass_swapped <= any_swap;
                    end
                end
                DRAIN: begin
                    if (out_valid && bus.out_ready) begin
                        if (rd_idx == LAST) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            rd_idx    <= '0;
                            state     <= LOAD;
                        end else begin
                            rd_idx   <= rd_nx;
                            out_data <= mem[rd_nx];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_controller.sv
// Randomized and directed checks of sort_controller against
// an ordering-rule reference model.
module tb_sort_controller;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] swap_count;

    sort_if sif ();

    sort_controller #(.DEPTH(D), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (sif.slave),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] vec     [D];
    logic [31:0] exp_out [D];
    int          exp_swaps;
    int          exp_passes;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // a must end up after b in the requested order
    function automatic bit after_f(logic [31:0] a,
                                   logic [31:0] b,
                                   bit desc);
        return desc ? ($signed(a) < $signed(b))
                    : ($signed(a) > $signed(b));
    endfunction

    // Swaps = inversions; passes = 1 + largest number of
    // out-of-order predecessors of any word, capped at D-1.
    task automatic model(input bit desc);
        logic [31:0] q [$];
        int maxd;
        int pos;
        exp_swaps = 0;
        maxd = 0;
        for (int j = 0; j < D; j++) begin
            int c = 0;
            for (int i = 0; i < j; i++)
                if (after_f(vec[i], vec[j], desc)) c++;
            exp_swaps += c;
            if (c > maxd) maxd = c;
        end
        exp_passes = (maxd + 1 > D - 1) ? D - 1 : maxd + 1;
        q = {};
        for (int k = 0; k < D; k++) begin
            pos = q.size();
            while (pos > 0 && after_f(q[pos-1], vec[k], desc))
                pos--;
            q.insert(pos, vec[k]);
        end
        for (int k = 0; k < D; k++) exp_out[k] = q[k];
    endtask

    task automatic load_words(input bit desc);
        int t;
        for (int k = 0; k < D; k++) begin
            sif.in_data    = vec[k];
            sif.descending = (k == 0) ? desc : ~desc;
            sif.in_valid   = 1'b1;
            t = 0;
            while (!sif.in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("load_ready", 32'(sif.in_ready), 32'd1);
            @(negedge clk);
        end
    endtask

    task automatic run_batch(input bit desc,
                             input int stall,
                             input bit hold_valid);
        int cyc;
        int t;
        int bad_rdy;
        int dones;
        model(desc);
        load_words(desc);
        if (!hold_valid) sif.in_valid = 1'b0;
        check("sort_in_ready", 32'(sif.in_ready), 32'd0);
        check("sort_busy", 32'(busy), 32'd1);
        cyc = 0;
        t = 0;
        bad_rdy = 0;
        while (!done && t < 100) begin
            if (busy && !sif.out_valid) cyc++;
            if (sif.in_ready) bad_rdy++;
            @(negedge clk);
            t++;
        end
        sif.in_valid = 1'b0;
        check("sort_no_accept", 32'(bad_rdy), 32'd0);
        check("sort_cycles", 32'(cyc), 32'(3 * exp_passes));
        check("done", 32'(done), 32'd1);
        check("swap_count", 32'(swap_count), 32'(exp_swaps));
        dones = 0;
        for (int k = 0; k < D; k++) begin
            sif.out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                check("stall_valid", 32'(sif.out_valid), 32'd1);
                check("stall_data", sif.out_data, exp_out[k]);
                dones += 32'(done);
                @(negedge clk);
            end
            sif.out_ready = 1'b1;
            check("out_valid", 32'(sif.out_valid), 32'd1);
            check("out_data", sif.out_data, exp_out[k]);
            dones += 32'(done);
            @(negedge clk);
        end
        sif.out_ready = 1'b0;
        check("done_pulses", 32'(dones), 32'd1);
        check("end_valid", 32'(sif.out_valid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_ready", 32'(sif.in_ready), 32'd1);
        check("swap_hold", 32'(swap_count), 32'(exp_swaps));
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(sif.in_ready), 32'd0);
        check("rst_out_valid", 32'(sif.out_valid), 32'd0);
        check("rst_out_data", sif.out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_swap_count", 32'(swap_count), 32'd0);
    endtask

    task automatic release_reset();
        int t;
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (!sif.in_ready && t < 5) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("rst_ready_latency", 32'(t <= 2), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sif.in_valid   = 1'b0;
        sif.in_data    = '0;
        sif.descending = 1'b0;
        sif.out_ready  = 1'b0;
        #12;
        check_reset_outputs();
        release_reset();

        vec = '{32'd5, 32'd3, -32'sd1, 32'd3};
        run_batch(1'b0, 0, 1'b0);

        vec = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_batch(1'b0, 1, 1'b0);

        vec = '{32'h80000000, 32'h7FFFFFFF,
                32'h00000000, 32'hFFFFFFFF};
        run_batch(1'b1, 0, 1'b0);

        vec = '{32'h33333333, 32'h33333333,
                32'h33333333, 32'h33333333};
        run_batch(1'b1, 0, 1'b1);

        vec = '{32'd9, -32'sd7, 32'd2, 32'd0};
        run_batch(1'b0, 3, 1'b0);

        // reset during the second SORT cycle
        vec = '{32'd8, 32'd6, 32'd7, 32'd5};
        load_words(1'b0);
        sif.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        release_reset();
        vec = '{32'd4, 32'd3, 32'd2, 32'd1};
        run_batch(1'b0, 0, 1'b0);
        check("post_rst_swaps", 32'(swap_count), 32'd6);

        for (int b = 0; b < 12; b++) begin
            for (int k = 0; k < D; k++)
                vec[k] = (b % 2 == 0) ? $urandom
                                      : 32'($urandom_range(0, 3)) - 32'd1;
            run_batch(1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
